ram256_wb_ctrl: RTL and testbench

Wishbone classic (B4, non-pipelined) 32-bit slave controller that sits directly upstream of the `RAM256` SRAM macro in the management SoC. It decodes a bus window and converts each Wishbone cycle into a single registered `EN0`/`WE0` access on the macro. For reads it captures the macro's registered `Do0` and returns it with a one-cycle acknowledge. Accesses outside the window complete with an error pulse and never touch the RAM.

---
 rtl/ram256_wb_ctrl.sv | 148 ++++++++++++++
 tb/tb_ram256_wb_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram256_wb_ctrl.sv
// ram256_wb_ctrl
// Wishbone classic (non-pipelined) 32-bit slave that fronts a RAM256 SRAM
// macro. Each bus cycle that hits the decoded window becomes exactly one
// registered EN0/WE0 access on the macro. Reads return the macro's registered
// Do0 through a capture register. Accesses outside the window end with an
// error pulse and leave the RAM untouched.
//
// Ports
//   CLK, RST        : single clock; synchronous active-high reset
//   wb_cyc_i/stb_i  : request qualifiers, sampled only while idle
//   wb_we_i         : 1 = write
//   wb_sel_i[3:0]   : byte lane selects (write only)
//   wb_adr_i[31:0]  : byte address; bits [1:0] ignored
//   wb_dat_i[31:0]  : write data
//   wb_dat_o[31:0]  : registered read data, held between reads
//   wb_ack_o        : one-cycle transfer-done pulse
//   wb_err_o        : one-cycle out-of-window pulse
//   ram_en0         : macro EN0, high one cycle per access
//   ram_we0[3:0]    : macro WE0 byte enables, high together with EN0
//   ram_a0          : macro word address, holds last value when idle
//   ram_di0[31:0]   : macro write data, holds last value when idle
//   ram_do0[31:0]   : macro read data (registered in the macro)
//   o_dbg_state     : current FSM state, for observation only
//
// Handshake: a request is wb_cyc_i & wb_stb_i seen in IDLE. The master holds
// address/data/controls until wb_ack_o or wb_err_o. Dropping wb_cyc_i in any
// busy state abandons the transfer: the FSM returns to IDLE with no ack/err.
module ram256_wb_ctrl #(
  parameter int          COLS      = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         A_WIDTH   = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               ram_en0,
  output logic [3:0]         ram_we0,
  output logic [A_WIDTH-1:0] ram_a0,
  output logic [31:0]        ram_di0,
  input  logic [31:0]        ram_do0,
  output logic [2:0]         o_dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  logic [2:0]         r_state;
  logic               r_is_wr;
  logic [31:0]        r_dat_o;
  logic               r_ack;
  logic               r_err;
  logic               r_en0;
  logic [3:0]         r_we0;
  logic [A_WIDTH-1:0] r_a0;
  logic [31:0]        r_di0;

  logic w_req;
  logic w_hit;
  logic w_unused_adr;

  assign w_req        = wb_cyc_i & wb_stb_i;
  assign w_hit        = (wb_adr_i[31:A_WIDTH+2] == BASE_ADDR[31:A_WIDTH+2]);
  // Byte offset within a word carries no meaning for a 32-bit-only slave.
  assign w_unused_adr = ^wb_adr_i[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_is_wr <= 1'b0;
      r_dat_o <= 32'h0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_en0   <= 1'b0;
      r_we0   <= 4'h0;
      r_a0    <= '0;
      r_di0   <= 32'h0;
    end else begin
      // Strobes are single-cycle by construction: cleared every cycle and
      // only set on the edge that enters the state they belong to.
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_en0 <= 1'b0;
      r_we0 <= 4'h0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              r_state <= S_ACCESS;
              r_is_wr <= wb_we_i;
              r_en0   <= 1'b1;
              r_we0   <= wb_we_i ? wb_sel_i : 4'h0;
              r_a0    <= wb_adr_i[A_WIDTH+1:2];
              r_di0   <= wb_dat_i;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // The macro samples EN0/WE0 at the end of this cycle, so an abort
          // here cannot cancel a write already presented to it.
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
          end else if (r_is_wr) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_dat_o <= ram_do0;
          end
        end
        S_ACK:   r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_dat_o    = r_dat_o;
  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign ram_en0     = r_en0;
  assign ram_we0     = r_we0;
  assign ram_a0      = r_a0;
  assign ram_di0     = r_di0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram256_wb_ctrl.sv
// Bench for ram256_wb_ctrl configured with two RAM columns at 0x1000.
// A behavioural RAM256 model (registered Do0, zero when EN0 is low) sits
// behind the controller. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, i.e. well away from the edge.
module tb_ram256_wb_ctrl;

  localparam int          COLS    = 2;
  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam int          AW      = 9;
  localparam logic [2:0]  ST_IDLE = 3'd0;

  logic          clk;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, dat_w;
  logic [31:0]   dat_o;
  logic          ack, err;
  logic          en0;
  logic [3:0]    we0;
  logic [AW-1:0] a0;
  logic [31:0]   di0;
  logic [31:0]   do0;
  logic [2:0]    dbg_state;

  int total;
  int bad;

  logic [31:0] mem [0:(1<<AW)-1];

  ram256_wb_ctrl #(.COLS(COLS), .BASE_ADDR(BASE)) dut (
    .CLK(clk), .RST(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .wb_err_o(err),
    .ram_en0(en0), .ram_we0(we0), .ram_a0(a0), .ram_di0(di0),
    .ram_do0(do0), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM256 macro model
  always @(posedge clk) begin
    if (en0) begin
      do0 <= mem[a0];
      for (int b = 0; b < 4; b++)
        if (we0[b]) mem[a0][8*b +: 8] <= di0[8*b +: 8];
    end else begin
      do0 <= 32'h0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one Wishbone cycle. k counts cycles after the request cycle T.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s,
                         output int ack_k, output int err_k, output logic [31:0] rdata,
                         output int en_cnt, output logic [AW-1:0] a_seen,
                         output logic [31:0] di_seen, output logic [3:0] we_seen);
    ack_k = 0; err_k = 0; rdata = 32'h0; en_cnt = 0;
    a_seen = '0; di_seen = 32'h0; we_seen = 4'h0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (en0) begin
        en_cnt++;
        a_seen = a0; di_seen = di0; we_seen = we0;
      end
      if (ack) begin ack_k = k; rdata = dat_o; end
      if (err) err_k = k;
      if (ack || err) break;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if ({dat_o, ack, err, en0, we0, a0, di0} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got dat=%h ack=%b err=%b en=%b we=%h a=%h di=%h, want all 0",
               dat_o, ack, err, en0, we0, a0, di0);
    end
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    int ak, ek, ec; logic [31:0] rd, dis; logic [AW-1:0] as; logic [3:0] ws;
    wb_xfer(1'b1, 32'h0000_1014, 32'hDEADBEEF, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (ak !== 2) begin bad++; $display("FAIL wr_ack_latency: got %0d want 2", ak); end
    total++;
    if (ec !== 1) begin bad++; $display("FAIL wr_en_cycles: got %0d want 1", ec); end
    total++;
    if ({as, dis, ws} !== {9'd5, 32'hDEADBEEF, 4'hF}) begin
      bad++; $display("FAIL wr_ram_bus: got a=%h di=%h we=%h want a=005 di=deadbeef we=f", as, dis, ws);
    end
    step();
    wb_xfer(1'b0, 32'h0000_1014, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (ak !== 3) begin bad++; $display("FAIL rd_ack_latency: got %0d want 3", ak); end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    total++;
    if ({ec, ws} !== {32'd1, 4'h0}) begin
      bad++; $display("FAIL rd_en_we: got en_cycles=%0d we=%h want 1 and 0", ec, ws);
    end
    step();
    // zero-select write: acknowledged, memory unchanged
    wb_xfer(1'b1, 32'h0000_1014, 32'h0BAD0BAD, 4'h0, ak, ek, rd, ec, as, dis, ws);
    total++;
    if ({ak, ec, ws} !== {32'd2, 32'd1, 4'h0}) begin
      bad++; $display("FAIL sel0_write: got ack_k=%0d en=%0d we=%h want 2 1 0", ak, ec, ws);
    end
    step();
    wb_xfer(1'b0, 32'h0000_1014, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL sel0_unchanged: got %h want deadbeef", rd); end
    // write does not disturb the read-data register
    step();
    wb_xfer(1'b1, 32'h0000_1018, 32'h12345678, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL dat_o_hold: got %h want deadbeef", dat_o); end
    step();
  endtask

  task automatic test_byte_lanes();
    int ak, ek, ec; logic [31:0] rd, dis; logic [AW-1:0] as; logic [3:0] ws;
    wb_xfer(1'b1, 32'h0000_101C, 32'h11223344, 4'hF, ak, ek, rd, ec, as, dis, ws);
    step();
    wb_xfer(1'b1, 32'h0000_101C, 32'hAABBCCDD, 4'b0101, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (ws !== 4'b0101) begin bad++; $display("FAIL lane_we: got %b want 0101", ws); end
    step();
    wb_xfer(1'b0, 32'h0000_101C, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL lane_merge: got %h want 11bb33dd", rd); end
    step();
  endtask

  task automatic test_window();
    int ak, ek, ec; logic [31:0] rd, dis; logic [AW-1:0] as; logic [3:0] ws;
    int en_after;
    wb_xfer(1'b1, 32'h0000_17FC, 32'h5A5A_A5A5, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if ({ak, as} !== {32'd2, 9'h1FF}) begin
      bad++; $display("FAIL top_word: got ack_k=%0d a0=%h want 2 1ff", ak, as);
    end
    step();
    wb_xfer(1'b0, 32'h0000_17FC, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (rd !== 32'h5A5A_A5A5) begin bad++; $display("FAIL top_word_rd: got %h want 5a5aa5a5", rd); end
    step();
    wb_xfer(1'b1, 32'h0000_2000, 32'hFFFF_FFFF, 4'hF, ak, ek, rd, ec, as, dis, ws);
    en_after = 0;
    for (int i = 0; i < 3; i++) begin step(); if (en0 || ack || err) en_after++; end
    total++;
    if ({ek, ak, ec, en_after} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL miss_high: got err_k=%0d ack_k=%0d en=%0d late=%0d want 1 0 0 0",
                      ek, ak, ec, en_after);
    end
    wb_xfer(1'b0, 32'h0000_0FFC, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if ({ek, ak, ec} !== {32'd1, 32'd0, 32'd0}) begin
      bad++; $display("FAIL miss_low: got err_k=%0d ack_k=%0d en=%0d want 1 0 0", ek, ak, ec);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int ak, ek, ec; logic [31:0] rd, dis; logic [AW-1:0] as; logic [3:0] ws;
    logic [31:0] exp_d [4];
    int ack_cyc [4];
    int n, cyc_i, consec;
    logic prev_ack;
    exp_d[0] = 32'hA0A0_0001; exp_d[1] = 32'hB1B1_0002;
    exp_d[2] = 32'hC2C2_0003; exp_d[3] = 32'hD3D3_0004;
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b1, BASE + 32'(4 * (40 + i)), exp_d[i], 4'hF, ak, ek, rd, ec, as, dis, ws);
      step();
    end
    n = 0; consec = 0; prev_ack = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'(4 * 40);
    for (cyc_i = 1; cyc_i <= 40 && n < 4; cyc_i++) begin
      step();
      if (ack && prev_ack) consec++;
      prev_ack = ack;
      if (ack) begin
        ack_cyc[n] = cyc_i;
        total++;
        if (dat_o !== exp_d[n]) begin
          bad++; $display("FAIL b2b_data%0d: got %h want %h", n, dat_o, exp_d[n]);
        end
        n++;
        adr = BASE + 32'(4 * (40 + n));
      end
    end
    cyc = 1'b0; stb = 1'b0;
    total++;
    if (n !== 4) begin bad++; $display("FAIL b2b_count: got %0d acks want 4", n); end
    else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (ack_cyc[i] - ack_cyc[i-1] !== 4) begin
          bad++; $display("FAIL b2b_period%0d: got %0d want 4", i, ack_cyc[i] - ack_cyc[i-1]);
        end
      end
    end
    total++;
    if (consec !== 0) begin bad++; $display("FAIL b2b_consec: got %0d want 0", consec); end
    step();
  endtask

  task automatic test_abort();
    int ak, ek, ec; logic [31:0] rd, dis; logic [AW-1:0] as; logic [3:0] ws;
    int stray;
    // read abandoned in CAPTURE
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_1014;
    step();  // ACCESS
    step();  // CAPTURE
    cyc = 1'b0; stb = 1'b0;
    step();
    total++;
    if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL abort_rd_state: got %0d want 0", dbg_state); end
    stray = 0;
    if (ack || err) stray++;
    for (int i = 0; i < 3; i++) begin step(); if (ack || err) stray++; end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL abort_rd_ack: got %0d strobes want 0", stray); end
    wb_xfer(1'b0, 32'h0000_1014, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if ({ak, rd} !== {32'd3, 32'hDEADBEEF}) begin
      bad++; $display("FAIL abort_rd_next: got ack_k=%0d data=%h want 3 deadbeef", ak, rd);
    end
    step();
    // write abandoned once ACCESS is reached
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h0000_1050; dat_w = 32'hCAFEF00D;
    step();  // ACCESS
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin step(); if (ack || err) stray++; end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL abort_wr_ack: got %0d strobes want 0", stray); end
    wb_xfer(1'b0, 32'h0000_1050, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_wr_data: got %h want cafef00d", rd); end
    step();
  endtask

  task automatic test_reset_mid();
    int ak, ek, ec; logic [31:0] rd, dis; logic [AW-1:0] as; logic [3:0] ws;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_101C;
    step();  // ACCESS
    rst = 1'b1;
    step();
    total++;
    if ({dat_o, ack, err, en0, we0, a0, di0, dbg_state} !== '0) begin
      bad++;
      $display("FAIL rst_mid: got dat=%h ack=%b err=%b en=%b we=%h a=%h di=%h st=%0d want all 0",
               dat_o, ack, err, en0, we0, a0, di0, dbg_state);
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    step();
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rst_mid_noack: got %b want 0", ack); end
    wb_xfer(1'b1, 32'h0000_1000, 32'h0F1E2D3C, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if (ak !== 2) begin bad++; $display("FAIL rst_wr0: got ack_k=%0d want 2", ak); end
    step();
    wb_xfer(1'b0, 32'h0000_1000, 32'h0, 4'hF, ak, ek, rd, ec, as, dis, ws);
    total++;
    if ({ak, rd} !== {32'd3, 32'h0F1E2D3C}) begin
      bad++; $display("FAIL rst_rd0: got ack_k=%0d data=%h want 3 0f1e2d3c", ak, rd);
    end
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_w = 32'h0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_window();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
